cc_stream_driver: RTL

Host-side driver for the cross-correlator's sample/result interface, i.e. the producer of start/m0/m1 and the consumer of index/done. It buffers two NSAMP-word sample records loaded by the host. On request it pulses the correlator's start, streams both records on exactly the cycles the correlator writes them, then waits for done. It returns the best-lag index to the host over a valid/ready result channel, with a watchdog.

---
 rtl/cc_stream_driver.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/cc_stream_driver.sv
// cc_stream_driver
// Host-side driver for the cross-correlator sample/result interface.
// The host loads NSAMP sample pairs into two buffers. A go pulse with full
// buffers pulses cc_start for one cycle and streams both records on
// cc_m0/cc_m1, one word per cycle starting the cycle after start. The
// driver then waits for cc_done under a watchdog and returns the lag index
// on a valid/ready result channel.
//
// Optional feature: define CC_DRV_CYCLE_COUNT_EN to add res_cycles, the
// saturating count of cycles from the ARM cycle to the cycle cc_done is
// sampled, inclusive of ARM. On abort it holds the cycles elapsed at abort.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   clr                 empty the sample buffers (only acted on in IDLE)
//   ld_valid/ld_ready   host sample-pair handshake, data on ld_a/ld_b
//   go                  start a run (IDLE with full buffers only)
//   busy                high from go acceptance until result accepted
//   cc_start            one-cycle start pulse to the correlator
//   cc_m0/cc_m1         registered sample stream to the correlator
//   cc_done/cc_index    done level and best-lag index from the correlator
//   res_valid/res_ready result handshake
//   res_index           captured lag index (0 on timeout)
//   res_timeout         run aborted by watchdog
//   res_cycles          (CC_DRV_CYCLE_COUNT_EN only) run cycle count
module cc_stream_driver #(
  parameter int DW      = 16,
  parameter int NSAMP   = 129,
  parameter int IW      = 10,
  parameter int TIMEOUT = 16384
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [DW-1:0] ld_a,
  input  logic [DW-1:0] ld_b,
  input  logic          go,
  output logic          busy,
  output logic          cc_start,
  output logic [DW-1:0] cc_m0,
  output logic [DW-1:0] cc_m1,
  input  logic          cc_done,
  input  logic [IW-1:0] cc_index,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [IW-1:0] res_index,
  output logic          res_timeout
`ifdef CC_DRV_CYCLE_COUNT_EN
  ,
  output logic [19:0]   res_cycles
`endif
);

  localparam int CW  = $clog2(NSAMP + 1);
  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  NSAMP_C = CW'(NSAMP);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [WDW-1:0] WD_ONE  = WDW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_STREAM = 3'd2,
    S_WAIT   = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  state_t         state_r;
  logic [CW-1:0]  wcnt_r;
  logic [CW-1:0]  rcnt_r;
  logic [WDW-1:0] wd_r;
  logic [DW-1:0]  mem_a_r [NSAMP];
  logic [DW-1:0]  mem_b_r [NSAMP];
  logic           busy_r;
  logic           cc_start_r;
  logic [DW-1:0]  cc_m0_r;
  logic [DW-1:0]  cc_m1_r;
  logic           res_valid_r;
  logic [IW-1:0]  res_index_r;
  logic           res_timeout_r;
  logic           ld_ready_s;
  logic           ld_fire_s;
  logic           full_s;
  logic           go_ok_s;

  // Load acceptance: only in IDLE with room, and clr blocks the write.
  always_comb begin
    ld_ready_s = 1'b0;
    if ((state_r == S_IDLE) && (wcnt_r < NSAMP_C) && !clr) begin
      ld_ready_s = 1'b1;
    end else begin
      ld_ready_s = 1'b0;
    end
  end

  assign ld_fire_s = ld_valid && ld_ready_s;
  assign full_s    = (wcnt_r == NSAMP_C);
  assign go_ok_s   = (state_r == S_IDLE) && go && full_s;

  // Sample buffers; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (ld_fire_s) begin
      mem_a_r[wcnt_r] <= ld_a;
      mem_b_r[wcnt_r] <= ld_b;
    end
  end

  // Run sequencer with registered correlator and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      wcnt_r        <= '0;
      rcnt_r        <= '0;
      wd_r          <= '0;
      busy_r        <= 1'b0;
      cc_start_r    <= 1'b0;
      cc_m0_r       <= '0;
      cc_m1_r       <= '0;
      res_valid_r   <= 1'b0;
      res_index_r   <= '0;
      res_timeout_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (clr) begin
            wcnt_r <= '0;
          end else if (ld_fire_s) begin
            wcnt_r <= wcnt_r + CNT_ONE;
          end
          if (go_ok_s) begin
            state_r    <= S_ARM;
            busy_r     <= 1'b1;
            cc_start_r <= 1'b1;
          end
        end
        S_ARM: begin
          // Word 0 is registered here so it appears the cycle after start.
          cc_start_r <= 1'b0;
          cc_m0_r    <= mem_a_r[0];
          cc_m1_r    <= mem_b_r[0];
          rcnt_r     <= CNT_ONE;
          state_r    <= S_STREAM;
        end
        S_STREAM: begin
          // rcnt is one ahead of the word on the outputs; at NSAMP the
          // last word is being presented and the outputs then hold.
          if (rcnt_r == NSAMP_C) begin
            state_r <= S_WAIT;
            wd_r    <= '0;
          end else begin
            cc_m0_r <= mem_a_r[rcnt_r];
            cc_m1_r <= mem_b_r[rcnt_r];
            rcnt_r  <= rcnt_r + CNT_ONE;
          end
        end
        S_WAIT: begin
          // done takes priority over the watchdog expiring in the same cycle.
          if (cc_done) begin
            res_index_r   <= cc_index;
            res_timeout_r <= 1'b0;
            res_valid_r   <= 1'b1;
            state_r       <= S_RESULT;
          end else if (wd_r == WD_LAST) begin
            res_index_r   <= '0;
            res_timeout_r <= 1'b1;
            res_valid_r   <= 1'b1;
            state_r       <= S_RESULT;
          end else begin
            wd_r <= wd_r + WD_ONE;
          end
        end
        S_RESULT: begin
          if (res_ready) begin
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CC_DRV_CYCLE_COUNT_EN
  logic [19:0] cyc_r;
  logic [19:0] res_cycles_r;

  // Run cycle counter: 1 during ARM, saturating, captured with the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_r        <= 20'd0;
      res_cycles_r <= 20'd0;
    end else begin
      if (go_ok_s) begin
        cyc_r <= 20'd1;
      end else if (((state_r == S_ARM) || (state_r == S_STREAM) ||
                    (state_r == S_WAIT)) && (cyc_r != 20'hFFFFF)) begin
        cyc_r <= cyc_r + 20'd1;
      end
      if ((state_r == S_WAIT) && (cc_done || (wd_r == WD_LAST))) begin
        res_cycles_r <= cyc_r;
      end
    end
  end

  assign res_cycles = res_cycles_r;
`endif

  assign ld_ready    = ld_ready_s;
  assign busy        = busy_r;
  assign cc_start    = cc_start_r;
  assign cc_m0       = cc_m0_r;
  assign cc_m1       = cc_m1_r;
  assign res_valid   = res_valid_r;
  assign res_index   = res_index_r;
  assign res_timeout = res_timeout_r;

endmodule
